// File: rtl/pla_exhaustive_sweeper.sv
// Exhaustive stimulus/response sweeper for a single-output PLA netlist.
// Walks every input vector once and accumulates on-set count, first hit and CRC.
module pla_exhaustive_sweeper #(
    parameter int          N    = 12,
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] x_out,
    output logic         x_valid,
    input  logic         y_in,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count,
    output logic [N-1:0] first_hit,
    output logic         hit_found,
    output logic [15:0]  signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        last;
    logic        clear;
    logic        sample;
    logic        fb;
    logic [15:0] sig_nxt;

    assign last    = (x_out == {N{1'b1}});
    assign fb      = signature[15] ^ y_in;
    assign sig_nxt = {signature[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                // abort outranks both pause and the terminal sample
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    sample = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out      <= '0;
            ones_count <= '0;
            first_hit  <= '0;
            hit_found  <= 1'b0;
            signature  <= SEED;
        end else if (clear) begin
            x_out      <= '0;
            ones_count <= '0;
            first_hit  <= '0;
            hit_found  <= 1'b0;
            signature  <= SEED;
        end else if (sample) begin
            ones_count <= ones_count + (N+1)'(y_in);
            signature  <= sig_nxt;
            if (y_in && !hit_found) begin
                first_hit <= x_out;
                hit_found <= 1'b1;
            end
            // terminal vector is held so x_out never wraps
            if (!last) begin
                x_out <= x_out + N'(1);
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign x_valid = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pla_exhaustive_sweeper.sv
// Directed bench for pla_exhaustive_sweeper with N=12.
// Netlist output is emulated by a mode-selected function of x_out.
module tb_pla_exhaustive_sweeper;

    localparam int N = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  x_out;
    logic          x_valid;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [N:0]    ones_count;
    logic [N-1:0]  first_hit;
    logic          hit_found;
    logic [15:0]   signature;

    int mode = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: const 0, 1: only at all-ones, 2: const 1, 3: x0
    assign y_in = (mode == 0) ? 1'b0 :
                  (mode == 1) ? (x_out == 12'hFFF) :
                  (mode == 2) ? 1'b1 : x_out[0];

    pla_exhaustive_sweeper #(
        .N(N),
        .POLY(16'h1021),
        .SEED(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .abort(abort),
        .x_out(x_out),
        .x_valid(x_valid),
        .y_in(y_in),
        .busy(busy),
        .done(done),
        .ones_count(ones_count),
        .first_hit(first_hit),
        .hit_found(hit_found),
        .signature(signature)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int m);
        logic [15:0] s;
        logic        y;
        logic        fb;
        s = 16'h0000;
        for (int v = 0; v < 4096; v++) begin
            y  = (m == 0) ? 1'b0 : (m == 1) ? (v == 4095) :
                 (m == 2) ? 1'b1 : v[0];
            fb = s[15] ^ y;
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(output int cnt);
        cnt = 0;
        while (busy && cnt < 10000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_x(input logic [N-1:0] v, input string tag);
        int k;
        k = 0;
        while (x_out !== v && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, {20'd0, x_out}, {20'd0, v});
    endtask

    initial begin
        int cnt;
        int pcnt;
        int cnt5;

        repeat (2) @(negedge clk);
        check("rst_x", {20'd0, x_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, x_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ones", {19'd0, ones_count}, 32'd0);
        check("rst_hit", {31'd0, hit_found}, 32'd0);
        check("rst_first", {20'd0, first_hit}, 32'd0);
        check("rst_sig", {16'd0, signature}, 32'h0000);
        rst = 1'b0;
        @(negedge clk);

        // all-zero function
        mode = 0;
        pulse_start();
        check("t1_x0", {20'd0, x_out}, 32'd0);
        run_sweep(cnt);
        check("t1_cycles", cnt, 4096);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_ones", {19'd0, ones_count}, 32'd0);
        check("t1_hit", {31'd0, hit_found}, 32'd0);
        check("t1_sig", {16'd0, signature}, 32'h0000);
        check("t1_x", {20'd0, x_out}, 32'hFFF);
        repeat (3) @(negedge clk);
        check("t1_frozen_done", {31'd0, done}, 32'd1);
        check("t1_frozen_x", {20'd0, x_out}, 32'hFFF);

        // single on-set vector at the terminal vector
        mode = 1;
        pulse_start();
        run_sweep(cnt);
        check("t2_cycles", cnt, 4096);
        check("t2_ones", {19'd0, ones_count}, 32'd1);
        check("t2_first", {20'd0, first_hit}, 32'hFFF);
        check("t2_hit", {31'd0, hit_found}, 32'd1);
        check("t2_sig", {16'd0, signature}, 32'h1021);

        // constant one
        mode = 2;
        pulse_start();
        run_sweep(cnt);
        check("t3_ones", {19'd0, ones_count}, 32'h1000);
        check("t3_first", {20'd0, first_hit}, 32'd0);
        check("t3_sig", {16'd0, signature}, {16'd0, crc_model(2)});

        // pause for 10 cycles at x_out=5
        mode = 3;
        pulse_start();
        cnt = 0;
        pcnt = 0;
        cnt5 = 0;
        while (busy && cnt < 10000) begin
            if (x_out == 12'd5) cnt5++;
            if (x_out == 12'd5 && pcnt < 10) begin
                pause = 1'b1;
                pcnt++;
            end else begin
                pause = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        pause = 1'b0;
        check("t4_hold5", cnt5, 11);
        check("t4_cycles", cnt, 4106);
        check("t4_ones", {19'd0, ones_count}, 32'd2048);
        check("t4_first", {20'd0, first_hit}, 32'd1);
        check("t4_sig", {16'd0, signature}, {16'd0, crc_model(3)});

        // abort at x_out=100
        pulse_start();
        wait_x(12'd100, "t5_reach100");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_ones", {19'd0, ones_count}, 32'd50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_idle_abort_ones", {19'd0, ones_count}, 32'd50);
        check("t5_idle_abort_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        check("t5_clear_ones", {19'd0, ones_count}, 32'd0);
        check("t5_clear_x", {20'd0, x_out}, 32'd0);
        run_sweep(cnt);
        check("t5_cycles", cnt, 4096);
        check("t5_full_ones", {19'd0, ones_count}, 32'd2048);
        check("t5_full_done", {31'd0, done}, 32'd1);

        // abort coinciding with the terminal sample
        mode = 2;
        pulse_start();
        wait_x(12'hFFF, "t5b_reachFFF");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_done", {31'd0, done}, 32'd0);
        check("t5b_busy", {31'd0, busy}, 32'd0);
        check("t5b_ones", {19'd0, ones_count}, 32'd4095);

        // start in RUN ignored, then reset mid-sweep
        mode = 3;
        pulse_start();
        wait_x(12'd50, "t6_reach50");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_start_ignored", {20'd0, x_out}, 32'd51);
        wait_x(12'd2000, "t6_reach2000");
        check("t6_pre_ones", {19'd0, ones_count}, 32'd1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_x", {20'd0, x_out}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_valid", {31'd0, x_valid}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_ones", {19'd0, ones_count}, 32'd0);
        check("t6_hit", {31'd0, hit_found}, 32'd0);
        check("t6_first", {20'd0, first_hit}, 32'd0);
        check("t6_sig", {16'd0, signature}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pla_exhaustive_sweeper.md
Name: pla_exhaustive_sweeper

Overview:
Sequential stimulus/response stage wrapped around one of our mockturtle-optimised single-output PLA netlists (N-input combinational function, one output bit).
- Upstream side: drives every input vector 0..2^N-1 onto the netlist inputs in order.
- Downstream side: consumes the netlist output and accumulates an on-set count, the first on-set vector and a 16-bit CRC signature.
- Post-optimisation netlists are checked against originals by comparing these results.

Parameters:
N, 12, number of netlist inputs (x0..x(N-1)); legal 1..20
POLY, 16'h1021, CRC feedback polynomial (bit 0 must be set)
SEED, 16'h0000, signature value loaded on start

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; honoured in IDLE and DONE, ignored in RUN
pause  input  1  hold current vector, no sampling, while high in RUN
abort  input  1  terminate sweep, return to IDLE
x_out  output  N  vector driven to netlist inputs, x_out[i] -> xi
x_valid  output  1  high when x_out is a live sweep vector (RUN state)
y_in  input  1  netlist output, combinational function of x_out
busy  output  1  high in RUN
done  output  1  high in DONE
ones_count  output  N+1  number of vectors with y_in=1
first_hit  output  N  lowest vector with y_in=1 (valid when hit_found)
hit_found  output  1  at least one on-set vector seen
signature  output  16  CRC over y_in in vector order

Behaviour:
- Reset (rst=1 at edge):
  - State -> IDLE.
  - x_out, ones_count, first_hit, hit_found, busy, done, x_valid -> 0.
  - signature -> SEED.
  - rst overrides start/abort/pause, including mid-sweep.
- States and transitions:
  - IDLE: start=1 -> RUN. On that edge, x_out<=0, ones_count<=0, hit_found<=0, first_hit<=0, signature<=SEED, done<=0.
  - RUN, un-paused edge:
    - Sample y_in for current x_out; update accumulators.
    - If x_out==2^N-1: -> DONE, x_out holds. Else x_out<=x_out+1.
  - RUN, pause=1: no state change at all.
  - RUN, abort=1: -> IDLE, no sample taken that edge, accumulators keep partial values, done stays 0. abort outranks pause.
  - DONE: outputs frozen. start=1 -> RUN with the same clears as from IDLE. abort=1 -> IDLE, accumulators kept.
  - start in RUN is ignored. abort in IDLE is a no-op.
- Timing:
  - y_in is combinational from x_out (no pipeline). It is sampled on the same edge x_out advances.
  - Un-paused sweep: start edge + exactly 2^N RUN edges. done rises the cycle after the last sample.
  - busy = x_valid = (state==RUN).
- Accumulator update per sampled y_in:
  - ones_count += y_in. Width N+1, so 2^N never overflows.
  - If y_in && !hit_found: first_hit<=x_out, hit_found<=1.
  - Signature:
    - fb = signature[15] ^ y_in
    - signature <= {signature[14:0],1'b0} ^ (fb ? POLY : 16'h0)
- Wrap-around: x_out never wraps. The terminal vector 2^N-1 is sampled exactly once; DONE entry prevents increment.
- Simultaneous abort and final sample edge: abort wins; the final vector is not counted, state -> IDLE.

Test Plan:
1. N=12, y_in tied 0, start pulse -> busy for 4096 cycles, done next cycle, ones_count=0, hit_found=0, signature=16'h0000, x_out=12'hFFF.
2. N=12, y_in=1 only when x_out==12'hFFF -> ones_count=1, first_hit=12'hFFF, hit_found=1, signature=16'h1021.
3. N=12, y_in tied 1 -> ones_count=13'h1000, first_hit=0. Signature equals the bench's reference CRC model over 4096 ones.
4. N=12, y_in=x_out[0]; pause high for 10 cycles at x_out=5 -> x_out holds 5 for 10 cycles, total busy cycles 4106, ones_count=2048, first_hit=1.
5. N=12, abort at x_out=100 with y_in=x_out[0] -> IDLE next cycle, done=0, ones_count=50. A following start clears and completes a full sweep normally.
6. rst asserted mid-sweep at x_out=2000 -> all outputs 0 and signature=SEED next cycle. start during RUN is ignored (x_out sequence unbroken).
